// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop add two WIDTH-bit
// operands LSB first, one bit per clock, with a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             state_dbg
);

    // Handshake: start is taken only on an edge where busy=0 (IDLE); busy stays
    // high for WIDTH cycles, then done pulses for one cycle with sum/cout/ovf valid.
    // start may be held high during the done cycle to chain operations.

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             s_bit;
    logic             maj_bit;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        s_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        maj_bit = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = maj_bit;
                // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                sum_d   = WIDTH'({s_bit, sum_q} >> 1);
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = maj_bit;
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ maj_bit;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8, 1 and 16 with a queue scoreboard
// holding {cout, ovf, sum} for every accepted start.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start8, cin8, busy8, done8, cout8, ovf8, st8;
    logic [7:0]  a8, b8, sum8;
    logic        start1, cin1, busy1, done1, cout1, ovf1, st1;
    logic [0:0]  a1, b1, sum1;
    logic        start16, cin16, busy16, done16, cout16, ovf16, st16;
    logic [15:0] a16, b16, sum16;

    logic [9:0]  exp8_q[$];
    logic [2:0]  exp1_q[$];
    logic [17:0] exp16_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .state_dbg(st8)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1), .state_dbg(st1)
    );
    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16), .state_dbg(st16)
    );

    // Reference models: {cout, ovf, sum}; ovf from operand/result sign rule.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] f;
        logic       v;
        f = {1'b0, a} + {1'b0, b} + {8'd0, c};
        v = (a[7] == b[7]) && (f[7] != a[7]);
        return {f[8], v, f[7:0]};
    endfunction

    function automatic logic [2:0] model1(input logic a, input logic b, input logic c);
        logic [1:0] f;
        logic       v;
        f = {1'b0, a} + {1'b0, b} + {1'b0, c};
        v = (a == b) && (f[0] != a);
        return {f[1], v, f[0]};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] f;
        logic        v;
        f = {1'b0, a} + {1'b0, b} + {16'd0, c};
        v = (a[15] == b[15]) && (f[15] != a[15]);
        return {f[16], v, f[15:0]};
    endfunction

    // Driver: issue one WIDTH=8 operation and wait (bounded) for done; no checking here.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output int busy_cnt, output bit got);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        exp8_q.push_back(model8(a, b, c));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 1; busy_cnt = 0; got = 1'b0;
        while (lat < 40) begin
            if (done8) begin
                got = 1'b1;
                break;
            end
            if (busy8) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
        start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
        start16 = 0; a16 = '0; b16 = '0; cin16 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy8, done8, cout8, ovf8, st8} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl8: got busy/done/cout/ovf/state=%b want 00000", {busy8, done8, cout8, ovf8, st8});
        end
        n_checks++;
        if (sum8 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sum8: got %h want 00", sum8);
        end
        n_checks++;
        if ({busy1, done1, sum1, cout1, ovf1, busy16, done16, cout16, ovf16} !== 9'b0 || sum16 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_w1_w16: got w1=%b w16=%b sum16=%h want all zero",
                     {busy1, done1, sum1, cout1, ovf1}, {busy16, done16, cout16, ovf16}, sum16);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        bit got;
        logic [9:0] exp;
        run8(8'd3, 8'd5, 1'b0, lat, bc, got);
        n_checks++;
        if (!got || lat != 9) begin
            n_fail++;
            $display("FAIL basic_latency: got done=%0d at cycle %0d want done at cycle 9", got, lat);
        end
        n_checks++;
        if (bc != 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d want 8", bc);
        end
        exp = exp8_q.pop_front();
        n_checks++;
        if ({cout8, ovf8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL basic_result: got %h want %h", {cout8, ovf8, sum8}, exp);
        end
        @(negedge clk);
        n_checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, ovf8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL basic_hold: got done=%b busy=%b res=%h want done=0 busy=0 res=%h",
                     done8, busy8, {cout8, ovf8, sum8}, exp);
        end
    endtask

    task automatic test_carry_ovf();
        logic [16:0] tbl [6];
        int lat, bc;
        bit got;
        logic [9:0] exp;
        tbl[0] = {8'hFF, 8'h01, 1'b0};
        tbl[1] = {8'hFF, 8'hFF, 1'b1};
        tbl[2] = {8'h7F, 8'h01, 1'b0};
        tbl[3] = {8'h80, 8'h80, 1'b0};
        tbl[4] = {8'h00, 8'h00, 1'b1};
        tbl[5] = {8'($urandom), 8'($urandom), 1'($urandom)};
        for (int i = 0; i < 6; i++) begin
            run8(tbl[i][16:9], tbl[i][8:1], tbl[i][0], lat, bc, got);
            exp = exp8_q.pop_front();
            n_checks++;
            if (!got || {cout8, ovf8, sum8} !== exp) begin
                n_fail++;
                $display("FAIL carry_ovf[%0d]: got done=%0d res=%h want res=%h", i, got, {cout8, ovf8, sum8}, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        logic [9:0] exp, res;
        res = '0;
        done_cnt = 0;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        exp8_q.push_back(model8(8'h12, 8'h34, 1'b1));
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                done_cnt++;
                res = {cout8, ovf8, sum8};
            end
        end
        exp = exp8_q.pop_front();
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL ignore_start_done_count: got %0d want 1", done_cnt);
        end
        n_checks++;
        if (res !== exp) begin
            n_fail++;
            $display("FAIL ignore_start_result: got %h want %h", res, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, done_cnt;
        bit got;
        logic [9:0] exp;
        run8(8'hFF, 8'h01, 1'b0, lat, bc, got);
        exp = exp8_q.pop_front();
        n_checks++;
        if (!got || {cout8, ovf8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL pre_reset_result: got done=%0d res=%h want %h", got, {cout8, ovf8, sum8}, exp);
        end
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) done_cnt++;
            if (k == 4) rst = 1'b1;
            if (k == 5) begin
                rst = 1'b0;
                n_checks++;
                if ({busy8, done8, cout8, ovf8} !== 4'b0 || sum8 !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_mid_run: got busy=%b done=%b cout=%b ovf=%b sum=%h want all zero",
                             busy8, done8, cout8, ovf8, sum8);
                end
            end
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", done_cnt);
        end
        run8(8'h21, 8'h42, 1'b1, lat, bc, got);
        exp = exp8_q.pop_front();
        n_checks++;
        if (!got || lat != 9 || {cout8, ovf8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL post_reset_op: got done=%0d lat=%0d res=%h want lat=9 res=%h",
                     got, lat, {cout8, ovf8, sum8}, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back8();
        int dones, cycles, prev;
        logic [9:0] exp;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
        exp8_q.push_back(model8(a8, b8, cin8));
        dones = 0; cycles = 0; prev = 0;
        while (dones < 6 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (done8) begin
                dones++;
                exp = exp8_q.pop_front();
                n_checks++;
                if ({cout8, ovf8, sum8} !== exp || cycles - prev != 9) begin
                    n_fail++;
                    $display("FAIL b2b8[%0d]: got res=%h gap=%0d want res=%h gap=9",
                             dones, {cout8, ovf8, sum8}, cycles - prev, exp);
                end
                prev = cycles;
                if (dones < 6) begin
                    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                    exp8_q.push_back(model8(a8, b8, cin8));
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        n_checks++;
        if (dones != 6) begin
            n_fail++;
            $display("FAIL b2b8_count: got %0d done pulses want 6", dones);
        end
        @(negedge clk);
    endtask

    task automatic test_width1();
        int dones, cycles, prev;
        logic [2:0] exp;
        logic [2:0] combo;
        combo = 3'd0;
        a1 = combo[2]; b1 = combo[1]; cin1 = combo[0]; start1 = 1'b1;
        exp1_q.push_back(model1(a1[0], b1[0], cin1));
        dones = 0; cycles = 0; prev = 0;
        while (dones < 8 && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (done1) begin
                dones++;
                exp = exp1_q.pop_front();
                n_checks++;
                if ({cout1, ovf1, sum1} !== exp || cycles - prev != 2) begin
                    n_fail++;
                    $display("FAIL w1[a,b,cin=%b]: got cout/ovf/sum=%b gap=%0d want %b gap=2",
                             3'(dones - 1), {cout1, ovf1, sum1}, cycles - prev, exp);
                end
                prev = cycles;
                if (dones < 8) begin
                    combo = 3'(dones);
                    a1 = combo[2]; b1 = combo[1]; cin1 = combo[0];
                    exp1_q.push_back(model1(a1[0], b1[0], cin1));
                end else begin
                    start1 = 1'b0;
                end
            end
        end
        start1 = 1'b0;
        n_checks++;
        if (dones != 8) begin
            n_fail++;
            $display("FAIL w1_count: got %0d done pulses want 8", dones);
        end
    endtask

    task automatic test_width16();
        int dones, cycles, prev;
        logic [17:0] exp;
        logic [32:0] ops [5];
        ops[0] = {16'hFFFF, 16'h0001, 1'b0};
        ops[1] = {16'h7FFF, 16'h0000, 1'b1};
        ops[2] = {16'h8000, 16'hFFFF, 1'b1};
        ops[3] = {16'($urandom), 16'($urandom), 1'($urandom)};
        ops[4] = {16'($urandom), 16'($urandom), 1'($urandom)};
        a16 = ops[0][32:17]; b16 = ops[0][16:1]; cin16 = ops[0][0]; start16 = 1'b1;
        exp16_q.push_back(model16(a16, b16, cin16));
        dones = 0; cycles = 0; prev = 0;
        while (dones < 5 && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (done16) begin
                dones++;
                exp = exp16_q.pop_front();
                n_checks++;
                if ({cout16, ovf16, sum16} !== exp || cycles - prev != 17) begin
                    n_fail++;
                    $display("FAIL w16[%0d]: got res=%h gap=%0d want res=%h gap=17",
                             dones, {cout16, ovf16, sum16}, cycles - prev, exp);
                end
                prev = cycles;
                if (dones < 5) begin
                    a16 = ops[dones][32:17]; b16 = ops[dones][16:1]; cin16 = ops[dones][0];
                    exp16_q.push_back(model16(a16, b16, cin16));
                end else begin
                    start16 = 1'b0;
                end
            end
        end
        start16 = 1'b0;
        n_checks++;
        if (dones != 5) begin
            n_fail++;
            $display("FAIL w16_count: got %0d done pulses want 5", dones);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry_ovf();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back8();
        test_width1();
        test_width16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
